// File: rtl/video_stream_tx_pkg.sv
// Shared types for the SRAM-to-pixel-stream frame transmitter: default widths,
// the transmit FSM state encoding and the sideband tag that travels with each read.
package video_stream_pkg;

  localparam int DATA_W_DEF = 24;
  localparam int ADDR_W_DEF = 20;

  typedef logic [DATA_W_DEF-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LINE  = 2'd1,
    BLANK = 2'd2,
    DRAIN = 2'd3
  } tx_state_t;

  typedef struct packed {
    logic start;
    logic valid;
    logic jump;
    logic last;
  } tag_t;

endpackage

// File: rtl/video_stream_tx_if.sv
// SRAM read port plus pixel-stream outputs of the frame transmitter.
// master = transmitter side, slave = SRAM / stream consumer side.
interface video_stream_tx_if
  import video_stream_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              Start_out;
  logic              H_Valid_out;
  logic              H_Jump_out;
  logic [DATA_W-1:0] Bmp_Data_out;

  modport master (
    output mem_en, mem_addr,
    input  mem_rdata,
    output Start_out, H_Valid_out, H_Jump_out, Bmp_Data_out
  );

  modport slave (
    input  mem_en, mem_addr,
    output mem_rdata,
    input  Start_out, H_Valid_out, H_Jump_out, Bmp_Data_out
  );
endinterface

// File: rtl/video_stream_tx_tag_pipe.sv
// Two-stage registered delay line carrying the per-read sideband tag, so it
// lines up with the registered SRAM data at the stream output.
module vs_tag_pipe
  import video_stream_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  tag_t i_tag,
  output logic o_valid_s1,
  output tag_t o_tag_s2
);
  tag_t r_s1;
  tag_t r_s2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= i_tag;
      r_s2 <= r_s1;
    end
  end

  assign o_valid_s1 = r_s1.valid;
  assign o_tag_s2   = r_s2;
endmodule

// File: rtl/video_stream_tx.sv
// Frame transmitter: raster-reads a W x H frame from SRAM and emits Start/H_Valid/H_Jump/data.
// Optional FRAME_CHECKSUM_EN adds frame_sum, the modulo-2^DATA_W sum of the pixels sent.
//
// state | meaning
// IDLE  | waiting for frame_start
// LINE  | one SRAM read per cycle, x = 0..W-1
// BLANK | HBLANK idle cycles between lines, no reads
// DRAIN | 2 cycles for the last reads to leave the tag pipe
module video_stream_tx
  import video_stream_pkg::*;
#(
  parameter int W         = 256,
  parameter int H         = 256,
  parameter int HBLANK    = 4,
  parameter int BASE_ADDR = 0,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF
)(
  input  logic              Clk_in,
  input  logic              Reset_n,
  input  logic              frame_start,
  output logic              busy,
  output logic              frame_done,
`ifdef FRAME_CHECKSUM_EN
  output logic [DATA_W-1:0] frame_sum,
`endif
  video_stream_tx_if.master bus
);
  localparam int XW = $clog2(W);
  localparam int YW = (H > 1) ? $clog2(H) : 1;
  localparam int BW = $clog2(HBLANK + 1);

  tx_state_t         r_state;
  tx_state_t         w_next;
  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic [BW-1:0]     r_blank;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              w_x_last;
  logic              w_y_last;
  logic              w_blank_tc;
  logic              w_mem_en;
  logic [ADDR_W-1:0] w_mem_addr;
  logic              w_valid_s1;
  tag_t              w_tag;
  tag_t              w_tag_s2;

  assign w_x_last   = (r_x == XW'(W - 1));
  assign w_y_last   = (r_y == YW'(H - 1));
  assign w_blank_tc = (r_blank == '0);

  always_ff @(posedge Clk_in or negedge Reset_n) begin
    if (!Reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (frame_start) w_next = LINE;
      LINE:    if (w_x_last) w_next = w_y_last ? DRAIN : BLANK;
      BLANK:   if (w_blank_tc) w_next = LINE;
      DRAIN:   if (w_blank_tc) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The first BLANK cycle tags the H_Jump; it reaches the stream right after the line's last pixel.
  always_comb begin
    w_tag      = '0;
    w_mem_en   = 1'b0;
    w_mem_addr = '0;
    case (r_state)
      LINE: begin
        w_mem_en    = 1'b1;
        w_mem_addr  = r_addr;
        w_tag.valid = 1'b1;
        w_tag.start = (r_x == '0) && (r_y == '0);
        w_tag.last  = w_x_last && w_y_last;
      end
      BLANK:   w_tag.jump = (r_blank == BW'(HBLANK - 1));
      default: ;
    endcase
  end

  // r_blank times both the line blanking and the 2-cycle drain.
  always_ff @(posedge Clk_in or negedge Reset_n) begin
    if (!Reset_n) begin
      r_x     <= '0;
      r_y     <= '0;
      r_blank <= '0;
      r_addr  <= '0;
    end else begin
      case (r_state)
        IDLE: if (frame_start) begin
          r_x     <= '0;
          r_y     <= '0;
          r_blank <= '0;
          r_addr  <= ADDR_W'(BASE_ADDR);
        end
        LINE: begin
          r_addr <= r_addr + ADDR_W'(1);
          if (w_x_last) begin
            r_x     <= '0;
            r_blank <= w_y_last ? BW'(1) : BW'(HBLANK - 1);
          end else begin
            r_x <= r_x + XW'(1);
          end
        end
        BLANK: begin
          if (w_blank_tc) r_y     <= r_y + YW'(1);
          else            r_blank <= r_blank - BW'(1);
        end
        DRAIN:   if (!w_blank_tc) r_blank <= r_blank - BW'(1);
        default: ;
      endcase
    end
  end

  vs_tag_pipe u_tag_pipe (
    .i_clk      (Clk_in),
    .i_rst_n    (Reset_n),
    .i_tag      (w_tag),
    .o_valid_s1 (w_valid_s1),
    .o_tag_s2   (w_tag_s2)
  );

  always_ff @(posedge Clk_in or negedge Reset_n) begin
    if (!Reset_n)        r_data <= '0;
    else if (w_valid_s1) r_data <= bus.mem_rdata;
    else                 r_data <= '0;
  end

`ifdef FRAME_CHECKSUM_EN
  logic [DATA_W-1:0] r_sum;

  always_ff @(posedge Clk_in or negedge Reset_n) begin
    if (!Reset_n)                              r_sum <= '0;
    else if (r_state == IDLE && frame_start)   r_sum <= '0;
    else if (w_valid_s1)                       r_sum <= r_sum + bus.mem_rdata;
  end

  assign frame_sum = r_sum;
`endif

  assign busy             = (r_state != IDLE);
  assign frame_done       = w_tag_s2.last;
  assign bus.mem_en       = w_mem_en;
  assign bus.mem_addr     = w_mem_addr;
  assign bus.Start_out    = w_tag_s2.start;
  assign bus.H_Valid_out  = w_tag_s2.valid;
  assign bus.H_Jump_out   = w_tag_s2.jump;
  assign bus.Bmp_Data_out = r_data;
endmodule

// File: tb/tb_video_stream_tx.sv
// Bench for video_stream_tx: three instances (4x2 frame, 4x1 frame at a wrapping base
// address, default 256x256) checked every cycle against a timeline model, plus literal checks.
module tb_video_stream_tx;
  import video_stream_pkg::*;

  localparam int BASE_B = 1048574;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic rst_a, rst_b, rst_c;
  logic fs_a = 1'b0, fs_b = 1'b0, fs_c = 1'b0;
  logic busy_a, busy_b, busy_c;
  logic done_a, done_b, done_c;
  logic [23:0] sum_a, sum_b, sum_c;

  video_stream_tx_if #(.ADDR_W(20), .DATA_W(24)) ifa ();
  video_stream_tx_if #(.ADDR_W(20), .DATA_W(24)) ifb ();
  video_stream_tx_if #(.ADDR_W(20), .DATA_W(24)) ifc ();

  video_stream_tx #(.W(4), .H(2), .HBLANK(2), .BASE_ADDR(0)) dut_a (
    .Clk_in(clk), .Reset_n(rst_a), .frame_start(fs_a), .busy(busy_a), .frame_done(done_a),
`ifdef FRAME_CHECKSUM_EN
    .frame_sum(sum_a),
`endif
    .bus(ifa));

  video_stream_tx #(.W(4), .H(1), .HBLANK(4), .BASE_ADDR(BASE_B)) dut_b (
    .Clk_in(clk), .Reset_n(rst_b), .frame_start(fs_b), .busy(busy_b), .frame_done(done_b),
`ifdef FRAME_CHECKSUM_EN
    .frame_sum(sum_b),
`endif
    .bus(ifb));

  video_stream_tx dut_c (
    .Clk_in(clk), .Reset_n(rst_c), .frame_start(fs_c), .busy(busy_c), .frame_done(done_c),
`ifdef FRAME_CHECKSUM_EN
    .frame_sum(sum_c),
`endif
    .bus(ifc));

  // Registered SRAMs: A holds mem[i]=i+1, B and C hold mem[i]=i.
  always @(posedge clk) if (ifa.mem_en) ifa.mem_rdata <= pixel_t'(ifa.mem_addr) + 24'd1;
  always @(posedge clk) if (ifb.mem_en) ifb.mem_rdata <= pixel_t'(ifb.mem_addr);
  always @(posedge clk) if (ifc.mem_en) ifc.mem_rdata <= pixel_t'(ifc.mem_addr);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Expected outputs t cycles after the accepting edge (t=0 is the first busy cycle).
  // Packing: {busy, done, mem_en, addr[19:0], start, valid, jump, data[23:0]}.
  function automatic logic [49:0] model(input int t, input int w, input int h, input int hb,
                                        input longint base, input int dofs);
    int p, tot, s, y, pos;
    logic b, d, en, st, v, j;
    logic [19:0] ad, a;
    logic [23:0] dt;
    b = 0; d = 0; en = 0; st = 0; v = 0; j = 0; ad = '0; a = '0; dt = '0;
    if (t < 0) return '0;
    p   = w + hb;
    tot = (h - 1) * p + w;
    b   = (t <= tot + 1);
    if (t < tot && (t % p) < w) begin
      en = 1;
      ad = 20'((base + longint'((t / p) * w + (t % p))) % 64'd1048576);
    end
    s = t - 2;
    if (s >= 0 && s < tot) begin
      pos = s % p;
      y   = s / p;
      if (pos < w) begin
        v  = 1;
        a  = 20'((base + longint'(y * w + pos)) % 64'd1048576);
        dt = 24'(a) + 24'(dofs);
        st = (s == 0);
        d  = (s == tot - 1);
      end else begin
        j = (pos == w);
      end
    end
    return {b, d, en, ad, st, v, j, dt};
  endfunction

  int t_a = -1, t_b = -1, t_c = -1;
  localparam int TOT_A = 10, TOT_B = 4, TOT_C = 255 * 260 + 256;

  always @(posedge clk or negedge rst_a)
    if (!rst_a) t_a = -1;
    else if (t_a >= 0) begin t_a++; if (t_a > TOT_A + 1) t_a = -1; end
    else if (fs_a) t_a = 0;

  always @(posedge clk or negedge rst_b)
    if (!rst_b) t_b = -1;
    else if (t_b >= 0) begin t_b++; if (t_b > TOT_B + 1) t_b = -1; end
    else if (fs_b) t_b = 0;

  always @(posedge clk or negedge rst_c)
    if (!rst_c) t_c = -1;
    else if (t_c >= 0) begin t_c++; if (t_c > TOT_C + 1) t_c = -1; end
    else if (fs_c) t_c = 0;

  logic [49:0] act_a, act_b, act_c;
  assign act_a = {busy_a, done_a, ifa.mem_en, ifa.mem_addr, ifa.Start_out, ifa.H_Valid_out, ifa.H_Jump_out, ifa.Bmp_Data_out};
  assign act_b = {busy_b, done_b, ifb.mem_en, ifb.mem_addr, ifb.Start_out, ifb.H_Valid_out, ifb.H_Jump_out, ifb.Bmp_Data_out};
  assign act_c = {busy_c, done_c, ifc.mem_en, ifc.mem_addr, ifc.Start_out, ifc.H_Valid_out, ifc.H_Jump_out, ifc.Bmp_Data_out};

  always @(negedge clk) begin
    check("model_A", 64'(act_a), 64'(model(t_a, 4, 2, 2, 0, 1)));
    check("model_B", 64'(act_b), 64'(model(t_b, 4, 1, 4, BASE_B, 0)));
    check("model_C", 64'(act_c), 64'(model(t_c, 256, 256, 4, 0, 0)));
  end

  int pix_a = 0, start_a = 0, fdone_a = 0;
  logic [23:0] start_data_a = '0;
  always @(negedge clk) begin
    if (ifa.H_Valid_out) pix_a++;
    if (ifa.Start_out) begin start_a++; start_data_a = ifa.Bmp_Data_out; end
    if (done_a) fdone_a++;
  end

  logic [19:0] addr_q_b[$];
  int jump_b = 0, fdone_b = 0;
  always @(negedge clk) begin
    if (ifb.mem_en) addr_q_b.push_back(ifb.mem_addr);
    if (ifb.H_Jump_out) jump_b++;
    if (done_b) fdone_b++;
  end

  int valid_c = 0, jump_c = 0, blank_c = 0;
  bit in_c = 0, done_prev_c = 0, after_seen_c = 0;
  logic busy_after_c = 1'b1;
  always @(negedge clk) begin
    if (done_prev_c && !after_seen_c) begin busy_after_c = busy_c; after_seen_c = 1; end
    done_prev_c = done_c;
    if (ifc.H_Valid_out) valid_c++;
    if (ifc.H_Jump_out) jump_c++;
    if (ifc.Start_out) in_c = 1;
    if (in_c && !ifc.H_Valid_out) blank_c++;
    if (done_c) in_c = 0;
  end

  task automatic wait_cyc(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  int t1_data[15] = '{0, 0, 0, 1, 2, 3, 4, 0, 0, 5, 6, 7, 8, 0, 0};

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    #2;
    check("reset_A", 64'(act_a), 64'd0);
    check("reset_B", 64'(act_b), 64'd0);
    check("reset_C", 64'(act_c), 64'd0);
`ifdef FRAME_CHECKSUM_EN
    check("reset_sum", 64'(sum_a), 64'd0);
`endif
    wait_cyc(2);
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;

    wait_cyc(4); fs_c = 1'b1;
    wait_cyc(5); fs_c = 1'b0;

    // Test 1: frame_start sampled at edge 10.
    wait_cyc(9); fs_a = 1'b1;
    for (int k = 9; k <= 23; k++) begin
      wait_cyc(k);
      if (k == 10) fs_a = 1'b0;
      @(negedge clk);
      check("t1_valid", 64'(ifa.H_Valid_out), 64'(t1_data[k-9] != 0));
      check("t1_data", 64'(ifa.Bmp_Data_out), 64'(t1_data[k-9]));
      check("t1_start", 64'(ifa.Start_out), 64'(k == 12));
      check("t1_jump", 64'(ifa.H_Jump_out), 64'(k == 16));
      check("t1_done", 64'(done_a), 64'(k == 21));
      check("t1_busy", 64'(busy_a), 64'(k >= 10 && k <= 21));
      check("t1_mem_en", 64'(ifa.mem_en), 64'((k >= 10 && k <= 13) || (k >= 16 && k <= 19)));
`ifdef FRAME_CHECKSUM_EN
      if (k == 21) check("t6_sum_done", 64'(sum_a), 64'h24);
`endif
    end

    // Test 2: frame_start held through the whole frame, including the done cycle.
    wait_cyc(30);
`ifdef FRAME_CHECKSUM_EN
    check("t6_sum_hold", 64'(sum_a), 64'h24);
`endif
    pix_a = 0; start_a = 0; fdone_a = 0;
    fs_a = 1'b1;
    wait_cyc(31);
`ifdef FRAME_CHECKSUM_EN
    check("t6_sum_clear", 64'(sum_a), 64'd0);
`endif
    wait_cyc(43); fs_a = 1'b0;
    wait_cyc(46);
    check("t2_pixels", 64'(pix_a), 64'd8);
    check("t2_starts", 64'(start_a), 64'd1);
    check("t2_dones", 64'(fdone_a), 64'd1);
    check("t2_idle", 64'(busy_a), 64'd0);

    // Test 3: reset in the middle of line 1, then a clean frame.
    wait_cyc(50);
    pix_a = 0; start_a = 0; fdone_a = 0;
    fs_a = 1'b1;
    wait_cyc(51); fs_a = 1'b0;
    wait_cyc(60);
    check("t3_pix_before", 64'(pix_a), 64'd5);
    rst_a = 1'b0;
    #1;
    check("t3_abort_outputs", 64'(act_a), 64'd0);
    wait_cyc(62);
    rst_a = 1'b1;
    check("t3_no_done", 64'(fdone_a), 64'd0);
    pix_a = 0; start_a = 0; fdone_a = 0;
    wait_cyc(64); fs_a = 1'b1;
    wait_cyc(65); fs_a = 1'b0;
    wait_cyc(78);
    check("t3_pixels", 64'(pix_a), 64'd8);
    check("t3_starts", 64'(start_a), 64'd1);
    check("t3_first_pixel", 64'(start_data_a), 64'd1);
    check("t3_dones", 64'(fdone_a), 64'd1);

    // Test 4: address wrap at the top of the 20-bit space.
    wait_cyc(80);
    addr_q_b.delete();
    fs_b = 1'b1;
    wait_cyc(81); fs_b = 1'b0;
    wait_cyc(92);
    check("t4_reads", 64'(addr_q_b.size()), 64'd4);
    if (addr_q_b.size() == 4) begin
      check("t4_addr0", 64'(addr_q_b[0]), 64'hFFFFE);
      check("t4_addr1", 64'(addr_q_b[1]), 64'hFFFFF);
      check("t4_addr2", 64'(addr_q_b[2]), 64'h00000);
      check("t4_addr3", 64'(addr_q_b[3]), 64'h00001);
    end
    check("t4_no_jump", 64'(jump_b), 64'd0);
    check("t4_done", 64'(fdone_b), 64'd1);

    // Test 5: full default frame, bounded wait.
    while (!after_seen_c && cyc < 70000) @(negedge clk);
    check("t5_finished", 64'(after_seen_c), 64'd1);
    check("t5_valid", 64'(valid_c), 64'd65536);
    check("t5_jumps", 64'(jump_c), 64'd255);
    check("t5_blanks", 64'(blank_c), 64'd1020);
    check("t5_busy_after_done", 64'(busy_after_c), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
